// File: rtl/fir_mac_filter.sv
// Sequential multiply-accumulate FIR: one tap per clock, coefficients fetched from an external 1-cycle ROM.
// Optional output clamping is enabled by defining FIR_SATURATE_EN; otherwise the output wraps.
module fir_mac_filter #(
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int TAPS      = 65,
    parameter int ADDR_W    = $clog2(TAPS),
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
    parameter int OUT_SHIFT = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] datain,
    input  logic              endata,
    output logic              ready,
    output logic [DATA_W-1:0] dataout,
    output logic              dataout_valid,
    output logic              overrun,
    output logic [ADDR_W-1:0] coefaddress,
    input  logic [COEF_W-1:0] coefdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_MAC, ST_OUT} state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    state_t                    r_state;
    logic [DATA_W-1:0]         r_x [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [ADDR_W-1:0]         r_cnt;
    logic [ADDR_W-1:0]         r_coefaddress;
    logic                      r_ready;
    logic [DATA_W-1:0]         r_dataout;
    logic                      r_dataout_valid;
    logic                      r_overrun;

    logic                              w_accept;
    logic [DATA_W-1:0]                 w_tap;
    logic signed [DATA_W+COEF_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]           w_prod_ext;
    logic [ADDR_W:0]                   w_next_addr;
    logic [ADDR_W-1:0]                 w_addr_clamped;
    logic [DATA_W-1:0]                 w_scaled;

    assign w_accept   = (r_state == ST_IDLE) && endata;
    assign w_tap      = r_x[r_cnt];
    assign w_prod     = $signed(w_tap) * $signed(coefdata);
    assign w_prod_ext = ACC_W'(w_prod);

    // Address runs two ahead of the tap being accumulated, pinned at the last tap.
    assign w_next_addr    = {1'b0, r_cnt} + (ADDR_W+1)'(2);
    assign w_addr_clamped = (w_next_addr >= {1'b0, LAST_TAP}) ? LAST_TAP : w_next_addr[ADDR_W-1:0];

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_shifted;
    assign w_shifted = r_acc >>> OUT_SHIFT;

    always_comb begin
        w_scaled = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_scaled = SAT_MAX[DATA_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_scaled = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    assign w_scaled = r_acc[OUT_SHIFT +: DATA_W];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                r_x[k] <= r_x[k-1];
            end
            r_x[0] <= datain;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_acc           <= '0;
            r_cnt           <= '0;
            r_coefaddress   <= '0;
            r_ready         <= 1'b1;
            r_dataout       <= '0;
            r_dataout_valid <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_overrun       <= endata && (r_state != ST_IDLE);
            r_dataout_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (endata) begin
                        r_acc         <= '0;
                        r_coefaddress <= '0;
                        r_ready       <= 1'b0;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_coefaddress <= ADDR_W'(1);
                    r_cnt         <= '0;
                    r_state       <= ST_MAC;
                end
                ST_MAC: begin
                    r_acc         <= r_acc + w_prod_ext;
                    r_cnt         <= r_cnt + ADDR_W'(1);
                    r_coefaddress <= w_addr_clamped;
                    if (r_cnt == LAST_TAP) begin
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_dataout       <= w_scaled;
                    r_dataout_valid <= 1'b1;
                    r_ready         <= 1'b1;
                    r_state         <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready         = r_ready;
    assign dataout       = r_dataout;
    assign dataout_valid = r_dataout_valid;
    assign overrun       = r_overrun;
    assign coefaddress   = r_coefaddress;

endmodule
